wb_host_master: RTL and testbench
=================================

// Module: wb_host_master
// PURPOSE
// - Wishbone classic initiator: turns single-word read/write commands into one bus cycle on a
//   32-bit Wishbone slave port (cyc/stb/we/sel/adr/dat, ack-terminated).
// - Sits in the bring-up/test harness and in the user area; drives user_proj's wbs_* port in place
//   of the management SoC. Returns read data or a timeout status per command.
// PARAMETERS
// - AW           32   address width (wbm_adr_o, cmd_adr_i)
// - DW           32   data width; sel width = DW/8
// - TIMEOUT_CYC  255  max cycles stb may wait for ack before abort; legal range 1..65535
// PORTS
// - wb_clk_i       in   1      single clock; all logic on rising edge
// - wb_rst_ni      in   1      asynchronous, active-low reset
// - cmd_valid_i    in   1      command offered
// - cmd_ready_o    out  1      command accepted when valid&ready at an edge
// - cmd_we_i       in   1      1=write, 0=read
// - cmd_adr_i      in   AW     byte address
// - cmd_dat_i      in   DW     write data
// - cmd_sel_i      in   DW/8   byte enables
// - rsp_valid_o    out  1      response held until rsp_ready_i
// - rsp_ready_i    in   1      response consumed when valid&ready at an edge
// - rsp_dat_o      out  DW     read data (0 for writes and timeouts)
// - rsp_timeout_o  out  1      1 = cycle aborted, no ack
// - wbm_cyc_o      out  1      Wishbone cycle
// - wbm_stb_o      out  1      Wishbone strobe (always equal to wbm_cyc_o)
// - wbm_we_o       out  1      write enable
// - wbm_sel_o      out  DW/8   byte select
// - wbm_adr_o      out  AW     address
// - wbm_dat_o      out  DW     write data
// - wbm_dat_i      in   DW     read data, valid with ack
// - wbm_ack_i      in   1      slave acknowledge
// BEHAVIOUR
// - Reset (async assert, sync release): state IDLE; all outputs 0 except cmd_ready_o=1;
//   timeout counter 0. Reset mid-cycle drops cyc/stb immediately; no response produced.
// - FSM IDLE -> BUS -> RSP -> IDLE. cmd_ready_o = (state==IDLE); commands held off otherwise.
// - IDLE: on cmd handshake at edge N, register we/adr/dat/sel onto wbm_*; cyc=stb=1 from N+1.
// - BUS: address/data/sel/we stable while cyc=1. Ack sampled at edge M: cyc=stb=0 and
//   rsp_valid_o=1 from M+1; rsp_dat_o = wbm_dat_i for reads, 0 for writes; rsp_timeout_o=0.
//   Minimum command-to-response latency 2 cycles (ack in first stb cycle).
// - Timeout: counter clears on entry to BUS, increments each BUS cycle without ack. If ack absent
//   for TIMEOUT_CYC consecutive stb cycles: cyc=stb=0, rsp_valid_o=1, rsp_timeout_o=1,
//   rsp_dat_o=0. Ack on the final counted cycle wins over timeout (normal completion).
// - Counter width = $clog2(TIMEOUT_CYC+1); never wraps (saturates at abort point).
// - RSP: rsp_* held stable until rsp_ready_i; handshake returns to IDLE, rsp_valid_o=0 next
//   cycle. No same-cycle bypass: next command accepted earliest the cycle after rsp handshake.
// - wbm_ack_i outside BUS ignored (late/spurious ack after timeout does not create a response).
// - wbm_adr/dat/sel/we retain last values when idle; only cyc/stb qualify them.
// STRUCTURE
// - Shared package wb_pkg: state enum {WBM_IDLE, WBM_BUS, WBM_RSP}, default AW/DW constants,
//   TIMEOUT_CYC default; reused by the user-side slave and bench models.
// - Single module; no sub-module (timeout counter is inline, one always_ff per register group).
// TESTING
// - Write adr=0x3000_0004 dat=0xDEAD_BEEF sel=0xF, slave acks 1st stb cycle -> cyc 1 cycle,
//   we=1, rsp_valid 2 cycles after accept, rsp_dat=0, timeout=0.
// - Read adr=0x3000_0000, ack after 3 wait cycles with dat_i=0x1234_5678 -> cyc/stb 4 cycles,
//   rsp_dat=0x1234_5678, rsp_timeout_o=0.
// - TIMEOUT_CYC=8, no ack -> stb high exactly 8 cycles, rsp_timeout_o=1, rsp_dat=0; ack
//   pulsed 2 cycles later -> no extra response.
// - Ack on 8th stb cycle (TIMEOUT_CYC=8) -> normal completion, rsp_timeout_o=0.
// - Backpressure: rsp_ready_i low 5 cycles, cmd_valid_i held high -> rsp_* stable, cmd_ready_o=0
//   throughout; next command accepted cycle after rsp handshake.
// - Assert wb_rst_ni low mid-BUS -> cyc/stb/rsp_valid 0 same cycle, cmd_ready_o=1 after release.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: initiator state encoding and default bus geometry.
// Reused by the host master, the user-side slave and bench models.
package wb_pkg;

  typedef enum logic [1:0] {
    WBM_IDLE,
    WBM_BUS,
    WBM_RSP
  } wbm_state_e;

  localparam int WB_AW          = 32;
  localparam int WB_DW          = 32;
  localparam int WB_TIMEOUT_CYC = 255;

endpackage

// File: rtl/wb_host_master.sv
// Wishbone classic initiator: one command becomes one ack-terminated bus cycle,
// answered by a held response carrying read data or a timeout flag.
module wb_host_master
  import wb_pkg::*;
#(
  parameter int AW          = WB_AW,
  parameter int DW          = WB_DW,
  parameter int TIMEOUT_CYC = WB_TIMEOUT_CYC
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic            cmd_we_i,
  input  logic [AW-1:0]   cmd_adr_i,
  input  logic [DW-1:0]   cmd_dat_i,
  input  logic [DW/8-1:0] cmd_sel_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [DW-1:0]   rsp_dat_o,
  output logic            rsp_timeout_o,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic            wbm_we_o,
  output logic [DW/8-1:0] wbm_sel_o,
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW-1:0]   wbm_dat_o,
  input  logic [DW-1:0]   wbm_dat_i,
  input  logic            wbm_ack_i
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYC);

  wbm_state_e    state, state_next;
  logic [CW-1:0] cnt;
  logic          cmd_fire, rsp_fire, bus_ack, bus_abort;

  assign cmd_ready_o = (state == WBM_IDLE);
  assign rsp_valid_o = (state == WBM_RSP);
  assign wbm_cyc_o   = (state == WBM_BUS);
  assign wbm_stb_o   = wbm_cyc_o;

  assign cmd_fire  = cmd_valid_i & cmd_ready_o;
  assign rsp_fire  = rsp_valid_o & rsp_ready_i;
  assign bus_ack   = wbm_cyc_o & wbm_ack_i;
  // Ack on the last counted cycle takes priority over the abort.
  assign bus_abort = wbm_cyc_o & ~wbm_ack_i & (cnt == CNT_LAST);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state <= WBM_IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      WBM_IDLE: if (cmd_fire) state_next = WBM_BUS;
      WBM_BUS:  if (bus_ack || bus_abort) state_next = WBM_RSP;
      WBM_RSP:  if (rsp_fire) state_next = WBM_IDLE;
      default:  state_next = WBM_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cnt <= '0;
    end else if (cmd_fire) begin
      cnt <= '0;
    end else if (wbm_cyc_o && !wbm_ack_i && cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbm_sel_o <= '0;
    end else if (cmd_fire) begin
      wbm_we_o  <= cmd_we_i;
      wbm_adr_o <= cmd_adr_i;
      wbm_dat_o <= cmd_dat_i;
      wbm_sel_o <= cmd_sel_i;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      rsp_dat_o     <= '0;
      rsp_timeout_o <= 1'b0;
    end else if (bus_ack) begin
      rsp_dat_o     <= wbm_we_o ? '0 : wbm_dat_i;
      rsp_timeout_o <= 1'b0;
    end else if (bus_abort) begin
      rsp_dat_o     <= '0;
      rsp_timeout_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_host_master.sv
// Directed bench for wb_host_master (TIMEOUT_CYC=8): write, waited read, timeout,
// late ack, ack on the final cycle, response backpressure and mid-cycle reset.
module tb_wb_host_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_dat;
  logic        wbm_cyc, wbm_stb, wbm_we, wbm_ack;
  logic [3:0]  wbm_sel;
  logic [31:0] wbm_adr, wbm_dat_o, wbm_dat_i;

  int checkCount = 0;
  int failCount  = 0;

  always #5 clk = ~clk;

  wb_host_master #(.AW(32), .DW(32), .TIMEOUT_CYC(8)) dut (
    .wb_clk_i      (clk),
    .wb_rst_ni     (rst_n),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_we_i      (cmd_we),
    .cmd_adr_i     (cmd_adr),
    .cmd_dat_i     (cmd_dat),
    .cmd_sel_i     (cmd_sel),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_dat_o     (rsp_dat),
    .rsp_timeout_o (rsp_timeout),
    .wbm_cyc_o     (wbm_cyc),
    .wbm_stb_o     (wbm_stb),
    .wbm_we_o      (wbm_we),
    .wbm_sel_o     (wbm_sel),
    .wbm_adr_o     (wbm_adr),
    .wbm_dat_o     (wbm_dat_o),
    .wbm_dat_i     (wbm_dat_i),
    .wbm_ack_i     (wbm_ack)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one command, plays the slave (ack after ackWait stall cycles, -1 = never)
  // and samples the response once cyc drops.
  task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                               input logic [3:0] sel, input int ackWait, input logic [31:0] ackDat,
                               output int stbCycles, output logic gotRsp,
                               output logic [31:0] rdat, output logic tmo);
    bit done = 0;
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    checkOutput("cmd_ready_idle", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    stbCycles = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (wbm_cyc) begin
        checkOutput("stb_eq_cyc", wbm_stb, 1);
        checkOutput("adr_hold", wbm_adr, adr);
        checkOutput("we_hold", wbm_we, we);
        checkOutput("dat_hold", wbm_dat_o, dat);
        checkOutput("sel_hold", wbm_sel, sel);
        checkOutput("cmd_ready_bus", cmd_ready, 0);
        if (ackWait == stbCycles) begin
          wbm_ack = 1'b1; wbm_dat_i = ackDat;
        end
        stbCycles++;
        tick();
        wbm_ack = 1'b0; wbm_dat_i = 32'hBAD0_0000;
      end else begin
        done = 1;
      end
    end
    if (!done) checkOutput("bus_bound", 0, 1);
    gotRsp = rsp_valid;
    rdat   = rsp_dat;
    tmo    = rsp_timeout;
  endtask

  task automatic finishRsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("rsp_drop", rsp_valid, 0);
    checkOutput("cmd_ready_back", cmd_ready, 1);
  endtask

  initial begin
    int          stbCycles;
    logic        gotRsp, tmo;
    logic [31:0] rdat;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b0; wbm_ack = 1'b0; wbm_dat_i = 32'hBAD0_0000;
    tick(); tick();
    checkOutput("rst_cmd_ready", cmd_ready, 1);
    checkOutput("rst_cyc", wbm_cyc, 0);
    checkOutput("rst_stb", wbm_stb, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_adr", wbm_adr, 0);
    checkOutput("rst_rsp_dat", rsp_dat, 0);
    rst_n = 1'b1;
    tick();

    $display("[TB] write, ack in first stb cycle");
    applyStimulus(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 0, 32'hFFFF_FFFF,
                  stbCycles, gotRsp, rdat, tmo);
    checkOutput("wr_stb_cycles", stbCycles, 1);
    checkOutput("wr_rsp_valid", gotRsp, 1);
    checkOutput("wr_rsp_dat", rdat, 0);
    checkOutput("wr_timeout", tmo, 0);
    finishRsp();

    $display("[TB] read, ack after 3 wait cycles");
    applyStimulus(1'b0, 32'h3000_0000, 32'h0, 4'hF, 3, 32'h1234_5678,
                  stbCycles, gotRsp, rdat, tmo);
    checkOutput("rd_stb_cycles", stbCycles, 4);
    checkOutput("rd_rsp_valid", gotRsp, 1);
    checkOutput("rd_rsp_dat", rdat, 32'h1234_5678);
    checkOutput("rd_timeout", tmo, 0);
    finishRsp();

    $display("[TB] timeout, then late acks");
    applyStimulus(1'b0, 32'h3000_0010, 32'h0, 4'h3, -1, 32'h0,
                  stbCycles, gotRsp, rdat, tmo);
    checkOutput("to_stb_cycles", stbCycles, 8);
    checkOutput("to_rsp_valid", gotRsp, 1);
    checkOutput("to_rsp_dat", rdat, 0);
    checkOutput("to_timeout", tmo, 1);
    wbm_ack = 1'b1; wbm_dat_i = 32'h5555_AAAA;
    tick();
    wbm_ack = 1'b0;
    checkOutput("to_late_ack_tmo", rsp_timeout, 1);
    checkOutput("to_late_ack_dat", rsp_dat, 0);
    finishRsp();
    wbm_ack = 1'b1;
    tick();
    wbm_ack = 1'b0;
    checkOutput("idle_ack_rsp", rsp_valid, 0);
    checkOutput("idle_ack_cyc", wbm_cyc, 0);
    tick();
    checkOutput("idle_ack_rsp2", rsp_valid, 0);

    $display("[TB] ack on final counted cycle");
    applyStimulus(1'b0, 32'h3000_0020, 32'h0, 4'hF, 7, 32'hCAFE_F00D,
                  stbCycles, gotRsp, rdat, tmo);
    checkOutput("last_stb_cycles", stbCycles, 8);
    checkOutput("last_rsp_valid", gotRsp, 1);
    checkOutput("last_rsp_dat", rdat, 32'hCAFE_F00D);
    checkOutput("last_timeout", tmo, 0);

    $display("[TB] response backpressure");
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0040; cmd_dat = 32'h0BAD_CAFE; cmd_sel = 4'h5;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("bp_rsp_valid", rsp_valid, 1);
      checkOutput("bp_rsp_dat", rsp_dat, 32'hCAFE_F00D);
      checkOutput("bp_cmd_ready", cmd_ready, 0);
      checkOutput("bp_cyc", wbm_cyc, 0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("bp_after_rsp_valid", rsp_valid, 0);
    checkOutput("bp_after_cmd_ready", cmd_ready, 1);
    checkOutput("bp_after_cyc", wbm_cyc, 0);
    tick();
    cmd_valid = 1'b0;
    checkOutput("bp_next_cyc", wbm_cyc, 1);
    checkOutput("bp_next_adr", wbm_adr, 32'h3000_0040);
    checkOutput("bp_next_sel", wbm_sel, 4'h5);
    wbm_ack = 1'b1;
    tick();
    wbm_ack = 1'b0;
    checkOutput("bp_next_rsp", rsp_valid, 1);
    checkOutput("bp_next_dat", rsp_dat, 0);
    finishRsp();

    $display("[TB] reset in the middle of a bus cycle");
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0080; cmd_sel = 4'hF;
    tick();
    cmd_valid = 1'b0;
    tick();
    checkOutput("mid_cyc_before", wbm_cyc, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_cyc", wbm_cyc, 0);
    checkOutput("mid_rst_stb", wbm_stb, 0);
    checkOutput("mid_rst_rsp", rsp_valid, 0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    checkOutput("mid_rel_cmd_ready", cmd_ready, 1);
    checkOutput("mid_rel_rsp", rsp_valid, 0);
    checkOutput("mid_rel_cyc", wbm_cyc, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
